// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
// Defines the queued write request, the arbiter FSM states and a rd -> one-hot helper.
// Used by: wb_arb_fifo, rf_wb_arbiter_if, rf_wb_arbiter.
package wb_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  // x0 is hard-wired, so it never contributes to a hazard mask.
  function automatic logic [XLEN-1:0] rd_onehot(input logic [RF_ADDR_W-1:0] rd);
    logic [XLEN-1:0] one;
    one = {{(XLEN-1){1'b0}}, 1'b1};
    return (rd == '0) ? '0 : (one << rd);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the pipeline write-back, MDU result and register-file write port signals.
// master: drives wb_* and mdu_valid/rd/data (pipeline + MDU side); slave: the arbiter.
// Slave returns mdu_ready, pipe_stall, rf_wen/rf_rd/rf_wdata and pending_mask.
interface rf_wb_arbiter_if;
  import wb_arb_pkg::*;

  logic                 wb_valid;
  logic [RF_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]      wb_data;
  logic                 mdu_valid;
  logic                 mdu_ready;
  logic [RF_ADDR_W-1:0] mdu_rd;
  logic [XLEN-1:0]      mdu_data;
  logic                 pipe_stall;
  logic                 rf_wen;
  logic [RF_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]      rf_wdata;
  logic [XLEN-1:0]      pending_mask;

  modport master (
    output wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, pipe_stall, rf_wen, rf_rd, rf_wdata, pending_mask
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, pipe_stall, rf_wen, rf_rd, rf_wdata, pending_mask
  );

endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// Small FIFO of queued MDU write-back requests with per-entry valid/rd taps.
// Latency: pushed entry is visible at head_o the cycle after the push.
// Backpressure: full_o when DEPTH entries held; push while full / pop while empty are ignored.
// Ports: clock, reset_n; push_i/push_dat_i; pop_i; head_o; full_o/empty_o; ent_vld_o/ent_rd_o taps.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                push_i,
  input  wb_req_t                             push_dat_i,
  input  logic                                pop_i,
  output wb_req_t                             head_o,
  output logic                                full_o,
  output logic                                empty_o,
  output logic [DEPTH-1:0]                    ent_vld_o,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]     ent_rd_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] vld_q;
  wb_req_t          mem_q [DEPTH];

  logic push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Push and pop never target the same slot: that would need count 0 (no pop)
  // or count DEPTH (no push), so both valid-bit updates can coexist.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= '0;
    end else begin
      if (push_ok) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; every consumer qualifies it with vld_q.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_comb begin
    ent_vld_o = vld_q;
    ent_rd_o  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd_o[i] = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single RF write port between pipeline write-back and queued MDU results.
// Latency: pipeline writes 0 cycles (combinational); MDU results no earlier than the cycle after accept.
// Backpressure: mdu_ready low while FIFO full; pipe_stall pulses one cycle to force a starved drain.
// Ports: clock, reset_n (async active-low), bus (rf_wb_arbiter_if.slave).
// Optional macro WB_ARB_PERF_EN adds perf_conflict_cnt / perf_force_cnt outputs.
module rf_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  rf_wb_arbiter_if.slave   bus
`ifdef WB_ARB_PERF_EN
  ,
  output logic [XLEN-1:0]  perf_conflict_cnt,
  output logic [XLEN-1:0]  perf_force_cnt
`endif
);

  localparam int WW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT - 1);

  arb_state_e state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic rdy_q;

  wb_req_t head;
  wb_req_t push_req;
  logic full, empty;
  logic push, pop;
  logic wb_go, pipe_grant, head_wait;
  logic [DEPTH-1:0] ent_vld;
  logic [DEPTH-1:0][RF_ADDR_W-1:0] ent_rd;

  // Held low through reset so nothing is accepted before the FIFO is known empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  assign bus.mdu_ready = rdy_q & ~full;

  // rd=0 results complete the handshake but are dropped: they would never write anything.
  assign push          = bus.mdu_valid & bus.mdu_ready & (bus.mdu_rd != '0);
  assign push_req.rd   = bus.mdu_rd;
  assign push_req.data = bus.mdu_data;

  // Keep the write port quiet while reset is asserted, whatever the pipeline drives.
  assign wb_go = bus.wb_valid & reset_n;

  // In FORCE the upstream is stalled, so the head always wins that cycle; a
  // pipeline write that violates the stall is dropped rather than losing the MDU entry.
  assign pop        = ~empty & ((state_q == FORCE) | ~wb_go);
  assign pipe_grant = wb_go & (state_q == NORMAL);
  assign head_wait  = ~empty & ~pop;

  wb_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_dat_i (push_req),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .ent_vld_o  (ent_vld),
    .ent_rd_o   (ent_rd)
  );

  // Write port mux.
  always_comb begin
    bus.rf_wen   = 1'b0;
    bus.rf_rd    = '0;
    bus.rf_wdata = '0;
    if (pop) begin
      bus.rf_wen   = (head.rd != '0);
      bus.rf_rd    = head.rd;
      bus.rf_wdata = head.data;
    end else if (pipe_grant) begin
      bus.rf_wen   = (bus.wb_rd != '0);
      bus.rf_rd    = bus.wb_rd;
      bus.rf_wdata = bus.wb_data;
    end
  end

  // Hazard mask from the FIFO's registered contents: a bit drops the cycle
  // after its pop, exactly when the RF already holds the value.
  always_comb begin
    bus.pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) bus.pending_mask = bus.pending_mask | rd_onehot(ent_rd[i]);
    end
  end

  // FSM: the stall is raised in the cycle the head reaches its wait limit so the
  // following (FORCE) cycle is guaranteed free of pipeline writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= NORMAL;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.pipe_stall = 1'b0;
    case (state_q)
      NORMAL: begin
        if (head_wait && (wait_q == WAIT_MAX)) begin
          state_d        = FORCE;
          bus.pipe_stall = 1'b1;
        end
      end
      FORCE:   state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (empty || pop)            wait_d = '0;
    else if (wait_q != WAIT_MAX) wait_d = wait_q + WW'(1);
  end

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_conflict_cnt <= '0;
      perf_force_cnt    <= '0;
    end else begin
      if (wb_go && !empty) perf_conflict_cnt <= perf_conflict_cnt + XLEN'(1);
      if (state_q == NORMAL && state_d == FORCE) perf_force_cnt <= perf_force_cnt + XLEN'(1);
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: pipe-only vector table plus hand-written
// sequences for MDU queueing, full FIFO, rd=0, starvation drain and mid-queue reset.
module tb_rf_wb_arbiter;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  rf_wb_arbiter_if bus ();

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_force_cnt;
`endif

  rf_wb_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_force_cnt    (perf_force_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wv;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        ew;
    logic [4:0]  er;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive just after the rising edge, sample at the falling edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.wb_valid  = 1'b0;
    bus.wb_rd     = 5'd0;
    bus.wb_data   = 32'd0;
    bus.mdu_valid = 1'b0;
    bus.mdu_rd    = 5'd0;
    bus.mdu_data  = 32'd0;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    idle_inputs();

    vecs[0] = '{1'b1, 5'd5,  32'hA5A5_0001, 1'b1, 5'd5,  32'hA5A5_0001};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 5'd0,  32'h0000_DEAD, 1'b0, 5'd0,  32'h0000_DEAD};
    vecs[3] = '{1'b0, 5'd9,  32'h0000_1234, 1'b0, 5'd0,  32'h0000_0000};
    vecs[4] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 5'd1,  32'h0000_0000};

    // Reset state
    #2;
    check("rst_ready", {31'd0, bus.mdu_ready}, 32'd0);
    check("rst_wen",   {31'd0, bus.rf_wen}, 32'd0);
    check("rst_rd",    {27'd0, bus.rf_rd}, 32'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_stall", {31'd0, bus.pipe_stall}, 32'd0);
    check("rst_mask",  bus.pending_mask, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
    settle();
    check("post_rst_ready", {31'd0, bus.mdu_ready}, 32'd1);

    // Pipe-only vector table (FIFO empty, zero-latency write)
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.wb_valid = vecs[i].wv;
      bus.wb_rd    = vecs[i].rd;
      bus.wb_data  = vecs[i].d;
      settle();
      check($sformatf("vec%0d_wen", i),   {31'd0, bus.rf_wen}, {31'd0, vecs[i].ew});
      check($sformatf("vec%0d_rd", i),    {27'd0, bus.rf_rd}, {27'd0, vecs[i].er});
      check($sformatf("vec%0d_wdata", i), bus.rf_wdata, vecs[i].ed);
      check($sformatf("vec%0d_stall", i), {31'd0, bus.pipe_stall}, 32'd0);
    end
    tick();
    idle_inputs();

    // MDU with idle pipeline: no bypass, mask then write next cycle
    tick();
    bus.mdu_valid = 1'b1;
    bus.mdu_rd    = 5'd7;
    bus.mdu_data  = 32'h0000_1234;
    settle();
    check("mdu_acc_ready", {31'd0, bus.mdu_ready}, 32'd1);
    check("mdu_no_bypass", {31'd0, bus.rf_wen}, 32'd0);
    check("mdu_mask0",     bus.pending_mask, 32'd0);
    tick();
    bus.mdu_valid = 1'b0;
    settle();
    check("mdu_mask_set", bus.pending_mask, 32'h0000_0080);
    check("mdu_wr_wen",   {31'd0, bus.rf_wen}, 32'd1);
    check("mdu_wr_rd",    {27'd0, bus.rf_rd}, 32'd7);
    check("mdu_wr_data",  bus.rf_wdata, 32'h0000_1234);
    tick();
    settle();
    check("mdu_mask_clr", bus.pending_mask, 32'd0);
    check("mdu_done_wen", {31'd0, bus.rf_wen}, 32'd0);

    // MDU rd=0: accepted, never queued or written
    tick();
    bus.mdu_valid = 1'b1;
    bus.mdu_rd    = 5'd0;
    bus.mdu_data  = 32'h0000_0099;
    settle();
    check("rd0_ready", {31'd0, bus.mdu_ready}, 32'd1);
    tick();
    bus.mdu_valid = 1'b0;
    settle();
    check("rd0_mask", bus.pending_mask, 32'd0);
    check("rd0_wen",  {31'd0, bus.rf_wen}, 32'd0);

    // Full FIFO with the pipeline writing every cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.wb_valid  = 1'b1;
      bus.wb_rd     = 5'd3;
      bus.wb_data   = 32'h0000_3333;
      bus.mdu_valid = 1'b1;
      bus.mdu_rd    = 5'(10 + i);
      bus.mdu_data  = 32'(100 + i);
      settle();
      check($sformatf("full_push%0d_ready", i), {31'd0, bus.mdu_ready}, 32'd1);
      check($sformatf("full_push%0d_rd", i), {27'd0, bus.rf_rd}, 32'd3);
    end
    tick();
    bus.mdu_rd   = 5'd14;
    bus.mdu_data = 32'd104;
    settle();
    check("full_ready",  {31'd0, bus.mdu_ready}, 32'd0);
    check("full_mask",   bus.pending_mask, 32'h0000_3C00);
    check("full_stall",  {31'd0, bus.pipe_stall}, 32'd0);
    check("full_pipe_rd", {27'd0, bus.rf_rd}, 32'd3);
    tick();
    bus.wb_valid = 1'b0;
    settle();
    check("full_pop_ready", {31'd0, bus.mdu_ready}, 32'd0);
    check("full_pop0_wen",  {31'd0, bus.rf_wen}, 32'd1);
    check("full_pop0_rd",   {27'd0, bus.rf_rd}, 32'd10);
    check("full_pop0_data", bus.rf_wdata, 32'd100);
    tick();
    settle();
    check("full_pop1_ready", {31'd0, bus.mdu_ready}, 32'd1);
    check("full_pop1_rd",    {27'd0, bus.rf_rd}, 32'd11);
    check("full_pop1_mask",  bus.pending_mask, 32'h0000_3800);
    tick();
    bus.mdu_valid = 1'b0;
    settle();
    check("full_pop2_rd",   {27'd0, bus.rf_rd}, 32'd12);
    check("full_pop2_mask", bus.pending_mask, 32'h0000_7000);
    tick();
    settle();
    check("full_pop3_rd", {27'd0, bus.rf_rd}, 32'd13);
    tick();
    settle();
    check("full_pop4_rd",   {27'd0, bus.rf_rd}, 32'd14);
    check("full_pop4_data", bus.rf_wdata, 32'd104);
    check("full_pop4_mask", bus.pending_mask, 32'h0000_4000);
    tick();
    settle();
    check("full_empty_wen",  {31'd0, bus.rf_wen}, 32'd0);
    check("full_empty_mask", bus.pending_mask, 32'd0);

    // Starvation: one entry, pipeline busy every cycle
    tick();
    bus.wb_valid  = 1'b1;
    bus.wb_rd     = 5'd2;
    bus.wb_data   = 32'h0000_00AA;
    bus.mdu_valid = 1'b1;
    bus.mdu_rd    = 5'd20;
    bus.mdu_data  = 32'h0000_0055;
    settle();
    check("starve_c0_stall", {31'd0, bus.pipe_stall}, 32'd0);
    for (int c = 1; c < 8; c++) begin
      tick();
      bus.mdu_valid = 1'b0;
      settle();
      check($sformatf("starve_c%0d_stall", c), {31'd0, bus.pipe_stall}, 32'd0);
      check($sformatf("starve_c%0d_rd", c), {27'd0, bus.rf_rd}, 32'd2);
    end
    tick();
    settle();
    check("starve_c8_stall", {31'd0, bus.pipe_stall}, 32'd1);
    check("starve_c8_rd",    {27'd0, bus.rf_rd}, 32'd2);
    check("starve_c8_mask",  bus.pending_mask, 32'h0010_0000);
    tick();
    bus.wb_valid = 1'b0;
    settle();
    check("starve_drain_stall", {31'd0, bus.pipe_stall}, 32'd0);
    check("starve_drain_wen",   {31'd0, bus.rf_wen}, 32'd1);
    check("starve_drain_rd",    {27'd0, bus.rf_rd}, 32'd20);
    check("starve_drain_data",  bus.rf_wdata, 32'h0000_0055);
    tick();
    bus.wb_valid = 1'b1;
    settle();
    check("starve_after_stall", {31'd0, bus.pipe_stall}, 32'd0);
    check("starve_after_mask",  bus.pending_mask, 32'd0);
    check("starve_after_rd",    {27'd0, bus.rf_rd}, 32'd2);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.wb_valid  = 1'b1;
      bus.mdu_valid = 1'b1;
      bus.mdu_rd    = 5'(5 + i);
      bus.mdu_data  = 32'(200 + i);
    end
    tick();
    bus.mdu_valid = 1'b0;
    settle();
    check("rstq_mask_before", bus.pending_mask, 32'h0000_00E0);
    tick();
    bus.wb_valid = 1'b0;
    reset_n      = 1'b0;
    #1;
    check("rstq_mask",  bus.pending_mask, 32'd0);
    check("rstq_wen",   {31'd0, bus.rf_wen}, 32'd0);
    check("rstq_ready", {31'd0, bus.mdu_ready}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    settle();
    check("rstq_rel_ready", {31'd0, bus.mdu_ready}, 32'd1);
    check("rstq_rel_wen",   {31'd0, bus.rf_wen}, 32'd0);
    check("rstq_rel_mask",  bus.pending_mask, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
